hdlverifier_axi_slave_mem: RTL and testbench



---
 rtl/hdlverifier_axi_pkg.sv | 20 ++
 rtl/hdlverifier_sdp_ram.sv | 33 +++
 rtl/hdlverifier_axi_slave_mem.sv | 215 +++++++++++++++++++++
 tb/tb_hdlverifier_axi_slave_mem.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_axi_pkg.sv
// Shared constants and FSM state types for the AXI4 slave memory.
package hdlverifier_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

  // WRAP is handled exactly like INCR, so only FIXED holds the index.
  function automatic logic burst_steps(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction

endpackage

// File: rtl/hdlverifier_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, 1-cycle synchronous read-first read port.
module hdlverifier_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hdlverifier_axi_slave_mem.sv
// AXI4 slave backed by on-chip RAM, one outstanding burst per direction.
// Optional HDLV_AXI_SLAVE_MEM_DECERR_EN: out-of-range start addresses answer DECERR.
module hdlverifier_axi_slave_mem
  import hdlverifier_axi_pkg::*;
#(
  parameter int ID_WIDTH       = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [ID_WIDTH-1:0]         axis_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axis_awaddr,
  input  logic [7:0]                  axis_awlen,
  input  logic [2:0]                  axis_awsize,
  input  logic [1:0]                  axis_awburst,
  input  logic                        axis_awvalid,
  output logic                        axis_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   axis_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axis_wstrb,
  input  logic                        axis_wlast,
  input  logic                        axis_wvalid,
  output logic                        axis_wready,
  output logic [ID_WIDTH-1:0]         axis_bid,
  output logic [1:0]                  axis_bresp,
  output logic                        axis_bvalid,
  input  logic                        axis_bready,
  input  logic [ID_WIDTH-1:0]         axis_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axis_araddr,
  input  logic [7:0]                  axis_arlen,
  input  logic [2:0]                  axis_arsize,
  input  logic [1:0]                  axis_arburst,
  input  logic                        axis_arvalid,
  output logic                        axis_arready,
  output logic [ID_WIDTH-1:0]         axis_rid,
  output logic [AXI_DATA_WIDTH-1:0]   axis_rdata,
  output logic [1:0]                  axis_rresp,
  output logic                        axis_rlast,
  output logic                        axis_rvalid,
  input  logic                        axis_rready,
  output logic [1:0]                  dbg_wr_state,
  output logic [1:0]                  dbg_rd_state
);

  localparam int B     = $clog2(AXI_DATA_WIDTH/8);
  localparam int IDX_W = MEM_DEPTH_LOG2;
  typedef logic [IDX_W-1:0] idx_t;

  // Handshake: a channel transfers on a rising edge where valid && ready are both high;
  // valid never waits for ready, and valid plus payload hold steady until that edge.
  wr_state_e w_state, w_state_d;
  rd_state_e r_state, r_state_d;
  logic [ID_WIDTH-1:0] w_id;
  idx_t                w_idx, r_idx;
  logic [7:0]          w_cnt, r_cnt;
  logic                w_step, w_err, w_dec, r_step, r_dec;
  logic                aw_hs, w_hs, ar_hs, r_hs, w_final, w_bad_last, r_fetch;
  logic                aw_dec, ar_dec;
  logic [AXI_DATA_WIDTH-1:0] ram_q;
  logic                unused_ok;

`ifdef HDLV_AXI_SLAVE_MEM_DECERR_EN
  assign aw_dec = (axis_awaddr >> (IDX_W + B)) != '0;
  assign ar_dec = (axis_araddr >> (IDX_W + B)) != '0;
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
`endif

  assign unused_ok = ^{axis_awsize, axis_arsize, axis_awaddr, axis_araddr};

  assign aw_hs      = axis_awvalid && axis_awready;
  assign w_hs       = axis_wvalid && axis_wready;
  assign ar_hs      = axis_arvalid && axis_arready;
  assign r_hs       = axis_rvalid && axis_rready;
  assign w_final    = (w_cnt == 8'd0);
  assign w_bad_last = (axis_wlast != w_final);

  assign axis_bid     = w_id;
  assign axis_rdata   = r_dec ? '0 : ram_q;
  assign dbg_wr_state = w_state;
  assign dbg_rd_state = r_state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_d;
      r_state <= r_state_d;
    end
  end

  always_comb begin
    w_state_d    = w_state;
    axis_awready = 1'b0;
    axis_wready  = 1'b0;
    axis_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        axis_awready = 1'b1;
        if (axis_awvalid) w_state_d = W_DATA;
      end
      W_DATA: begin
        axis_wready = 1'b1;
        if (axis_wvalid && w_final) w_state_d = W_RESP;
      end
      W_RESP: begin
        axis_bvalid = 1'b1;
        if (axis_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d    = r_state;
    axis_arready = 1'b0;
    axis_rvalid  = 1'b0;
    r_fetch      = 1'b0;
    case (r_state)
      R_IDLE: begin
        axis_arready = 1'b1;
        if (axis_arvalid) r_state_d = R_FETCH;
      end
      R_FETCH: begin
        r_fetch   = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        axis_rvalid = 1'b1;
        // Prefetch the next beat in the handshake cycle so beats run back to back.
        if (axis_rready) begin
          if (axis_rlast) r_state_d = R_IDLE;
          else            r_fetch   = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Burst length always comes from awlen; wlast only grades the response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id       <= '0;
      w_idx      <= '0;
      w_cnt      <= '0;
      w_step     <= 1'b0;
      w_err      <= 1'b0;
      w_dec      <= 1'b0;
      axis_bresp <= RESP_OKAY;
    end else if (aw_hs) begin
      w_id   <= axis_awid;
      w_idx  <= axis_awaddr[B +: IDX_W];
      w_cnt  <= axis_awlen;
      w_step <= burst_steps(axis_awburst);
      w_err  <= 1'b0;
      w_dec  <= aw_dec;
    end else if (w_hs) begin
      w_cnt <= w_cnt - 8'd1;
      w_err <= w_err | w_bad_last;
      if (w_step) w_idx <= w_idx + 1'b1;
      if (w_final) begin
        axis_bresp <= w_dec ? RESP_DECERR :
                      (w_err || w_bad_last) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      axis_rid   <= '0;
      axis_rresp <= RESP_OKAY;
      axis_rlast <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_step     <= 1'b0;
      r_dec      <= 1'b0;
    end else if (ar_hs) begin
      axis_rid   <= axis_arid;
      axis_rresp <= ar_dec ? RESP_DECERR : RESP_OKAY;
      r_idx      <= axis_araddr[B +: IDX_W];
      r_cnt      <= axis_arlen;
      r_step     <= burst_steps(axis_arburst);
      r_dec      <= ar_dec;
    end else if (r_fetch) begin
      if (r_step) r_idx <= r_idx + 1'b1;
      if (r_state == R_FETCH) begin
        axis_rlast <= (r_cnt == 8'd0);
      end else begin
        axis_rlast <= (r_cnt == 8'd1);
        r_cnt      <= r_cnt - 8'd1;
      end
    end else if (r_hs && axis_rlast) begin
      axis_rlast <= 1'b0;
    end
  end

  hdlverifier_sdp_ram #(
    .DATA_W (AXI_DATA_WIDTH),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk   (aclk),
    .rst_n (aresetn),
    .we    (w_hs && !w_dec),
    .waddr (w_idx),
    .wbe   (axis_wstrb),
    .wdata (axis_wdata),
    .re    (r_fetch),
    .raddr (r_idx),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_hdlverifier_axi_slave_mem.sv
// Randomized scoreboard bench for hdlverifier_axi_slave_mem against a word-array memory model.
`timescale 1ns/1ps
module tb_hdlverifier_axi_slave_mem;

  localparam int ID_W  = 1;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;
  localparam int R_W   = ID_W + 2 + 1 + DW;
  localparam int B_W   = ID_W + 2;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
  logic [AW-1:0]   awaddr = '0, araddr = '0;
  logic [7:0]      awlen = '0, arlen = '0;
  logic [2:0]      awsize = 3'd2, arsize = 3'd2;
  logic [1:0]      awburst = 2'b01, arburst = 2'b01, bresp, rresp;
  logic            awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic            bready = 1'b0, rready = 1'b0;
  logic            awready, arready, wready, bvalid, rvalid, rlast;
  logic [DW-1:0]   wdata = '0, rdata;
  logic [DW/8-1:0] wstrb = '0;
  logic [1:0]      dbg_wr_state, dbg_rd_state;

  hdlverifier_axi_slave_mem #(
    .ID_WIDTH(ID_W), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MEM_DEPTH_LOG2(DL)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_awid(awid), .axis_awaddr(awaddr), .axis_awlen(awlen), .axis_awsize(awsize),
    .axis_awburst(awburst), .axis_awvalid(awvalid), .axis_awready(awready),
    .axis_wdata(wdata), .axis_wstrb(wstrb), .axis_wlast(wlast), .axis_wvalid(wvalid),
    .axis_wready(wready),
    .axis_bid(bid), .axis_bresp(bresp), .axis_bvalid(bvalid), .axis_bready(bready),
    .axis_arid(arid), .axis_araddr(araddr), .axis_arlen(arlen), .axis_arsize(arsize),
    .axis_arburst(arburst), .axis_arvalid(arvalid), .axis_arready(arready),
    .axis_rid(rid), .axis_rdata(rdata), .axis_rresp(rresp), .axis_rlast(rlast),
    .axis_rvalid(rvalid), .axis_rready(rready),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [R_W-1:0] exp_r_q[$];
  logic [B_W-1:0] exp_b_q[$];
  logic [DW-1:0]  mem_model [DEPTH];
  logic [DW-1:0]  wd_q[$];
  logic [3:0]     ws_q[$];
  logic [DW-1:0]  rd_override_q[$];
  int rready_mode = 0;   // 0 random, 1 always high, 2 toggle each cycle
  bit sb_on = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit dec_model(input logic [AW-1:0] a);
`ifdef HDLV_AXI_SLAVE_MEM_DECERR_EN
    return (a >> (DL + 2)) != 0;
`else
    return 1'b0 & a[0];
`endif
  endfunction

  // ---------------- ready drivers ----------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rready_mode)
        0:       rready = 1'($urandom_range(0, 1));
        1:       rready = 1'b1;
        2:       rready = ~rready;
        default: rready = 1'b0;
      endcase
      bready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  logic [R_W-1:0] r_got, r_held;
  logic [B_W-1:0] b_got, b_held;
  bit r_stalled = 1'b0, b_stalled = 1'b0;

  always @(negedge aclk) begin
    if (aresetn && sb_on) begin
      if (rvalid) begin
        r_got = {rid, rresp, rlast, rdata};
        if (r_stalled) check("r_stable", 64'(r_got), 64'(r_held));
        if (rready) begin
          if (exp_r_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL r_unexpected: got %h expected no beat", r_got);
          end else check("r_beat", 64'(r_got), 64'(exp_r_q.pop_front()));
          r_stalled = 1'b0;
        end else begin
          r_stalled = 1'b1;
          r_held    = r_got;
        end
      end else r_stalled = 1'b0;
      if (bvalid) begin
        b_got = {bid, bresp};
        if (b_stalled) check("b_stable", 64'(b_got), 64'(b_held));
        if (bready) begin
          if (exp_b_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected: got %h expected no response", b_got);
          end else check("b_resp", 64'(b_got), 64'(exp_b_q.pop_front()));
          b_stalled = 1'b0;
        end else begin
          b_stalled = 1'b1;
          b_held    = b_got;
        end
      end else b_stalled = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input int len,
                             input logic [1:0] burst, input int bad_last);
    int idx, budget;
    bit dec, err;
    idx = int'((addr >> 2) % DEPTH);
    dec = dec_model(addr);
    err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (!dec) for (int b = 0; b < 4; b++) if (ws_q[i][b]) mem_model[idx][b*8 +: 8] = wd_q[i][b*8 +: 8];
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
      if (i == bad_last) err = 1'b1;
    end
    exp_b_q.push_back({id, dec ? 2'b11 : (err ? 2'b10 : 2'b00)});

    @(posedge aclk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awburst = burst;
    budget = 0;
    @(negedge aclk);
    while (!awready && budget < 50) begin @(negedge aclk); budget++; end
    if (!awready) begin n_cmp++; n_bad++; $display("FAIL aw_timeout: got awready=0 expected 1"); end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check("wready_after_aw", 64'(wready), 64'(1));
    check("awready_busy", 64'(awready), 64'(0));

    for (int i = 0; i <= len; i++) begin
      @(posedge aclk); #1;
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      wvalid = 1'b1; wdata = wd_q[i]; wstrb = ws_q[i];
      wlast = (i == len) ^ (i == bad_last);
      budget = 0;
      @(negedge aclk);
      while (!wready && budget < 50) begin @(negedge aclk); budget++; end
      if (!wready) begin n_cmp++; n_bad++; $display("FAIL w_timeout: got wready=0 expected 1"); end
    end
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge aclk);
    check("bvalid_after_last_w", 64'(bvalid), 64'(1));
    budget = 0;
    while (exp_b_q.size() != 0 && budget < 200) begin @(negedge aclk); budget++; end
    if (exp_b_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL b_timeout: got %0d pending expected 0", exp_b_q.size());
      exp_b_q.delete();
    end
    wd_q.delete();
    ws_q.delete();
  endtask

  task automatic read_burst(input logic [ID_W-1:0] id, input logic [AW-1:0] addr, input int len,
                            input logic [1:0] burst);
    int idx, budget;
    bit dec;
    logic [DW-1:0] d;
    idx = int'((addr >> 2) % DEPTH);
    dec = dec_model(addr);
    for (int i = 0; i <= len; i++) begin
      if (dec) d = '0;
      else if (rd_override_q.size() != 0) d = rd_override_q[i];
      else d = mem_model[idx];
      exp_r_q.push_back({id, dec ? 2'b11 : 2'b00, 1'(i == len), d});
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    rd_override_q.delete();

    @(posedge aclk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len); arburst = burst;
    budget = 0;
    @(negedge aclk);
    while (!arready && budget < 50) begin @(negedge aclk); budget++; end
    if (!arready) begin n_cmp++; n_bad++; $display("FAIL ar_timeout: got arready=0 expected 1"); end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    check("rvalid_n1", 64'(rvalid), 64'(0));
    check("arready_busy", 64'(arready), 64'(0));
    @(negedge aclk);
    check("rvalid_n2", 64'(rvalid), 64'(1));
    budget = 0;
    while (exp_r_q.size() != 0 && budget < 2000) begin @(negedge aclk); budget++; end
    if (exp_r_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL r_timeout: got %0d pending expected 0", exp_r_q.size());
      exp_r_q.delete();
    end
  endtask

  task automatic fill_random(input int len, input bit full_strb);
    for (int i = 0; i <= len; i++) begin
      wd_q.push_back($urandom);
      ws_q.push_back(full_strb ? 4'hF : 4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len;
    logic [AW-1:0] a;
    logic [1:0] bu;
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
    @(negedge aclk);
    check("rst_awready", 64'(awready), 64'(1));
    check("rst_arready", 64'(arready), 64'(1));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rlast", 64'(rlast), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_rresp", 64'(rresp), 64'(0));
    check("rst_bresp", 64'(bresp), 64'(0));
    check("rst_bid", 64'(bid), 64'(0));
    check("rst_rid", 64'(rid), 64'(0));

    // W presented with no AW must not be accepted
    @(posedge aclk); #1; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("wready_before_aw", 64'(wready), 64'(0));
    end
    @(posedge aclk); #1; wvalid = 1'b0;

    // give every word a known value
    for (int k = 0; k < 4; k++) begin
      fill_random(255, 1'b1);
      write_burst(1'b0, AW'(k * 1024), 255, 2'b01, -1);
    end

    // directed: INCR write/readback
    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'hA0 + i); ws_q.push_back(4'hF); end
    write_burst(1'b1, 32'h100, 3, 2'b01, -1);
    for (int i = 0; i < 4; i++) rd_override_q.push_back(32'hA0 + i);
    read_burst(1'b1, 32'h100, 3, 2'b01);

    // directed: byte strobes
    wd_q.push_back(32'h1122_3344); ws_q.push_back(4'hF);
    write_burst(1'b0, 32'h200, 0, 2'b01, -1);
    wd_q.push_back(32'hFFFF_FFFF); ws_q.push_back(4'b0101);
    write_burst(1'b0, 32'h200, 0, 2'b01, -1);
    rd_override_q.push_back(32'h11FF_33FF);
    read_burst(1'b0, 32'h200, 0, 2'b01);

    // directed: FIXED burst leaves last beat at one word
    for (int i = 1; i <= 3; i++) begin wd_q.push_back(DW'(i)); ws_q.push_back(4'hF); end
    write_burst(1'b1, 32'h40, 2, 2'b00, -1);
    rd_override_q.push_back(32'h3);
    read_burst(1'b1, 32'h40, 0, 2'b01);

    // 256-beat read with rready toggling
    rready_mode = 2;
    read_burst(1'b0, 32'h0, 255, 2'b01);
    rready_mode = 0;

    // wlast early on beat 1, then wlast missing on the final beat
    fill_random(3, 1'b1);
    write_burst(1'b1, 32'h300, 3, 2'b01, 1);
    fill_random(2, 1'b1);
    write_burst(1'b0, 32'h310, 2, 2'b10, 2);
    read_burst(1'b1, 32'h300, 6, 2'b10);

    // address just past the RAM: DECERR with the macro, alias of word 0 without
    read_burst(1'b0, AW'(1) << (DL + 2), 1, 2'b01);
    fill_random(1, 1'b1);
    write_burst(1'b1, AW'(1) << (DL + 2), 1, 2'b01, -1);
    read_burst(1'b1, 32'h0, 1, 2'b01);

    // random sequential traffic, including wrap past the top word
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(0, 15);
      a   = AW'($urandom_range(0, 4095)) & ~AW'(3);
      if ($urandom_range(0, 5) == 0) a = a | (AW'(1) << (DL + 2 + $urandom_range(0, 3)));
      bu  = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        fill_random(len, 1'b0);
        write_burst(1'($urandom_range(0, 1)), a, len, bu, ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1);
      end else begin
        read_burst(1'($urandom_range(0, 1)), a, len, bu);
      end
    end

    // concurrent read and write to disjoint halves
    for (int t = 0; t < 5; t++) begin
      fill_random(15, 1'b0);
      fork
        write_burst(1'b1, AW'($urandom_range(0, 496)) << 2, 15, 2'b01, -1);
        read_burst(1'b0, AW'($urandom_range(512, 1008)) << 2, 15, 2'b01);
      join
    end

    // reset in the middle of a read burst
    sb_on = 1'b0;
    rready_mode = 1;
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = 32'h0; arlen = 8'd20; arburst = 2'b01;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    repeat (5) @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_rvalid", 64'(rvalid), 64'(0));
    check("midrst_rlast", 64'(rlast), 64'(0));
    check("midrst_rdata", 64'(rdata), 64'(0));
    check("midrst_arready", 64'(arready), 64'(1));
    @(posedge aclk); #2 aresetn = 1'b1;
    exp_r_q.delete();
    exp_b_q.delete();
    @(negedge aclk);
    sb_on = 1'b1;
    rready_mode = 0;
    fill_random(3, 1'b1);
    write_burst(1'b0, 32'h500, 3, 2'b01, -1);
    read_burst(1'b0, 32'h500, 3, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
